// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Each line holds valid, dirty, a tag and four 32-bit words. Loads and stores
// that hit in IDLE complete with no stall. A miss writes back the victim line
// if it is dirty, then allocates the requested line. The request then
// re-evaluates as a hit in IDLE.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   proc_addr          word address: [1:0] word, [INDEX_W+1:2] index, rest tag
//   proc_read/write    load / store request (both set acts as a store)
//   proc_wdata         store word
//   proc_rdata         load word of the indexed line (combinational)
//   proc_stall         pipeline hold (combinational)
//   mem_read/write     backing-memory line read / write request
//   mem_addr           backing-memory line address
//   mem_wdata          line being written back
//   mem_rdata          line returned by memory
//   mem_ready          memory completes the current transfer this cycle
module data_cache #(
  parameter int unsigned INDEX_W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [29:0]  proc_addr,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  localparam int unsigned LINES = 1 << INDEX_W;
  localparam int unsigned TAG_W = 28 - INDEX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t state;
  state_t state_next;

  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;
  logic [TAG_W-1:0] tags  [LINES];
  logic [127:0]     lines [LINES];

  logic [1:0]         offset;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic [6:0]         word_lsb;
  logic               request;
  logic               hit;
  logic               store_hit;
  logic               fill;

  // Address split and lookup
  assign offset    = proc_addr[1:0];
  assign index     = proc_addr[INDEX_W+1:2];
  assign tag       = proc_addr[29:INDEX_W+2];
  assign word_lsb  = {offset, 5'd0};
  assign request   = proc_read | proc_write;
  assign hit       = valid[index] && (tags[index] == tag);
  assign store_hit = (state == IDLE) && proc_write && hit;
  assign fill      = (state == ALLOCATE) && mem_ready;

  // Loads see the stored word before any same-cycle store lands
  assign proc_rdata = lines[index][word_lsb +: 32];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        // mem_ready is deliberately not looked at here
        if (request && !hit) begin
          state_next = (valid[index] && dirty[index]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        if (mem_ready) begin
          state_next = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (mem_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs; memory strobes decode from state so reset clears them at once
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = proc_addr[29:2];
    mem_wdata  = lines[index];
    proc_stall = request && !((state == IDLE) && hit);
    case (state)
      WRITEBACK: begin
        mem_write = 1'b1;
        mem_addr  = {tags[index], index};
      end
      ALLOCATE: begin
        mem_read = 1'b1;
      end
      default: ;
    endcase
  end

  // Line status bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill) begin
      valid[index] <= 1'b1;
      dirty[index] <= 1'b0;
    end else if (store_hit) begin
      dirty[index] <= 1'b1;
    end
  end

  // Tag and data arrays (contents are don't-care until valid)
  always_ff @(posedge clk) begin
    if (fill) begin
      lines[index] <= mem_rdata;
      tags[index]  <= tag;
    end else if (store_hit) begin
      lines[index][word_lsb +: 32] <= proc_wdata;
    end
  end

endmodule
